// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, constants and state type for the standardizer datapath
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 26;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  // Longest left-shift chain: leading one at bit 0 moved up to the hidden bit.
  localparam logic [4:0] SHIFT_CAP = 5'd24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_HOLD
  } std_state_t;

endpackage

// File: rtl/std_round_rne.sv
// rtl/std_round_rne.sv - round-to-nearest-even on a normalized 26-bit mantissa
// Increments [25:1] on guard & (sticky | lsb), handles carry-out, subnormal promotion and infinity.
module std_round_rne
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic [EXP_W-1:0]  exp_val,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac,
  output logic [EXP_W-1:0]  exp_res
);

  logic              guard;
  logic              lsb;
  logic              inc;
  logic [MANT_W-2:0] rounded;
  logic [EXP_W:0]    exp_wide;

  assign guard   = mant[0];
  assign lsb     = mant[1];
  assign inc     = guard & (sticky | lsb);
  assign rounded = mant[MANT_W-1:1] + {{(MANT_W-2){1'b0}}, inc};

  always_comb begin
    exp_wide = {1'b0, exp_val};
    frac     = rounded[FRAC_W-1:0];
    if (rounded[MANT_W-2]) begin
      // Rounding overflowed past the hidden bit: value is exactly 2^(e+1).
      exp_wide = exp_wide + (EXP_W+1)'(1);
      frac     = '0;
    end else if ((exp_val == '0) && rounded[FRAC_W]) begin
      exp_wide = (EXP_W+1)'(1);
    end
    if (exp_wide >= {1'b0, EXP_SPECIAL}) begin
      exp_wide = {1'b0, EXP_SPECIAL};
      frac     = '0;
    end
    exp_res = exp_wide[EXP_W-1:0];
  end

endmodule

// File: rtl/standardizer_seq.sv
// rtl/standardizer_seq.sv - bit-serial normalize + RNE round of a raw add/sub result
// Optional status outputs enabled by defining STANDARDIZER_FLAGS_EN.
module standardizer_seq
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mantis_in,
  input  logic              loss,
  input  logic              operator_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [FRAC_W-1:0] mantis_out
`ifdef STANDARDIZER_FLAGS_EN
  ,
  output logic              flag_overflow,
  output logic              flag_underflow,
  output logic              flag_inexact
`endif
);

  std_state_t        state;
  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0]  exp_r;
  logic              sign_r;
  logic              op_r;
  logic              sticky;
  logic [4:0]        shift_cnt;

  logic [FRAC_W-1:0] rnd_frac;
  logic [EXP_W-1:0]  rnd_exp;

  logic              can_shift_left;

  assign can_shift_left = !mant[MANT_W-1] && !mant[MANT_W-2] && (exp_r > 8'd1);

  std_round_rne u_round (
    .mant    (mant),
    .exp_val (exp_r),
    .sticky  (sticky),
    .frac    (rnd_frac),
    .exp_res (rnd_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      sign_out   <= 1'b0;
      exp_out    <= '0;
      mantis_out <= '0;
      mant       <= '0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      op_r       <= 1'b0;
      sticky     <= 1'b0;
      shift_cnt  <= '0;
`ifdef STANDARDIZER_FLAGS_EN
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_r    <= sign_in;
            exp_r     <= exp_in;
            mant      <= mantis_in;
            sticky    <= loss;
            op_r      <= operator_in;
            shift_cnt <= '0;
            in_ready  <= 1'b0;
            state     <= (exp_in == EXP_SPECIAL) ? S_HOLD : S_NORM;
          end
        end

        S_NORM: begin
          if (mant == '0) begin
            // Exact cancellation of x - x yields +0.
            sign_out   <= sign_r & ~op_r;
            exp_out    <= '0;
            mantis_out <= '0;
            out_valid  <= 1'b1;
`ifdef STANDARDIZER_FLAGS_EN
            flag_overflow  <= 1'b0;
            flag_underflow <= sticky;
            flag_inexact   <= 1'b0;
`endif
            state      <= S_HOLD;
          end else if (mant[MANT_W-1]) begin
            mant   <= {1'b0, mant[MANT_W-1:1]};
            exp_r  <= exp_r + 8'd1;
            sticky <= sticky | mant[0];
            state  <= S_ROUND;
          end else if (can_shift_left && (shift_cnt != SHIFT_CAP)) begin
            mant      <= {mant[MANT_W-2:0], 1'b0};
            exp_r     <= exp_r - 8'd1;
            shift_cnt <= shift_cnt + 5'd1;
          end else if (!mant[MANT_W-2] && (exp_r <= 8'd1)) begin
            exp_r <= '0;
            state <= S_ROUND;
          end else begin
            state <= S_ROUND;
          end
        end

        S_ROUND: begin
          sign_out   <= sign_r;
          exp_out    <= rnd_exp;
          mantis_out <= rnd_frac;
          out_valid  <= 1'b1;
`ifdef STANDARDIZER_FLAGS_EN
          flag_overflow  <= (rnd_exp == EXP_SPECIAL);
          flag_underflow <= (rnd_exp == '0) && (mant[0] | sticky);
          flag_inexact   <= mant[0] | sticky;
`endif
          state      <= S_HOLD;
        end

        S_HOLD: begin
          if (!out_valid) begin
            // Special operands arrive here straight from IDLE and are published one cycle later.
            sign_out   <= sign_r;
            exp_out    <= EXP_SPECIAL;
            mantis_out <= mant[FRAC_W:1];
            out_valid  <= 1'b1;
`ifdef STANDARDIZER_FLAGS_EN
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_shift_cap: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == S_NORM) && (mant != '0) && can_shift_left) |-> (shift_cnt < SHIFT_CAP));
`endif

endmodule

// File: tb/tb_standardizer_seq.sv
// tb/tb_standardizer_seq.sv - directed + randomized check of standardizer_seq against an arithmetic model
module tb_standardizer_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [25:0] mantis_in;
  logic        loss;
  logic        operator_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] mantis_out;
`ifdef STANDARDIZER_FLAGS_EN
  logic        flag_overflow;
  logic        flag_underflow;
  logic        flag_inexact;
`endif

  int checks = 0;
  int errors = 0;

  standardizer_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign_in     (sign_in),
    .exp_in      (exp_in),
    .mantis_in   (mantis_in),
    .loss        (loss),
    .operator_in (operator_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sign_out    (sign_out),
    .exp_out     (exp_out),
    .mantis_out  (mantis_out)
`ifdef STANDARDIZER_FLAGS_EN
    ,
    .flag_overflow  (flag_overflow),
    .flag_underflow (flag_underflow),
    .flag_inexact   (flag_inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: value-level normalize then round-half-even, using plain integer arithmetic.
  task automatic model(input logic s, input logic [7:0] e, input logic [25:0] m, input logic l,
                       input logic op, output logic xs, output int xe, output int xf,
                       output int lat, output bit of, output bit uf, output bit inx);
    longint unsigned mm, q;
    int ee, p, need, allow, k;
    bit st, g;
    mm = m; ee = e; st = l; of = 0; uf = 0; inx = 0;
    if (e == 8'hFF) begin
      xs = s; xe = 255; xf = int'((mm >> 1) & 64'h7FFFFF); lat = 1;
    end else if (m == 26'd0) begin
      xs = s & ~op; xe = 0; xf = 0; lat = 1; uf = l;
    end else begin
      k = 0;
      if (mm >= (64'd1 << 25)) begin
        st = st | mm[0];
        mm = mm >> 1;
        ee = ee + 1;
      end else begin
        p = 0;
        for (int b = 0; b < 25; b++) if (mm[b]) p = b;
        need  = 24 - p;
        allow = (ee > 1) ? ee - 1 : 0;
        k     = (need < allow) ? need : allow;
        mm    = mm << k;
        ee    = ee - k;
        if (mm < (64'd1 << 24)) ee = 0;
      end
      g = mm[0];
      q = mm >> 1;
      if (g && (st || q[0])) q = q + 1;
      if (q >= (64'd1 << 24)) begin
        ee = ee + 1;
        q  = 0;
      end else if (ee == 0 && q >= (64'd1 << 23)) begin
        ee = 1;
      end
      if (ee >= 255) begin
        ee = 255;
        q  = 0;
      end
      xs = s; xe = ee; xf = int'(q & 64'h7FFFFF); lat = k + 2;
      of = (ee == 255); uf = (ee == 0) && (g || st); inx = g || st;
    end
  endtask

  task automatic run_op(input logic s, input logic [7:0] e, input logic [25:0] m, input logic l,
                        input logic op, input int hold_cycles);
    logic xs;
    int xe, xf, xlat, lat;
    bit of, uf, inx;
    model(s, e, m, l, op, xs, xe, xf, xlat, of, uf, inx);
    check("in_ready_idle", in_ready, 1);
    sign_in = s; exp_in = e; mantis_in = m; loss = l; operator_in = op; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 40);
    check("latency", lat, xlat);
    check("sign_out", sign_out, xs);
    check("exp_out", exp_out, xe);
    check("mantis_out", mantis_out, xf);
`ifdef STANDARDIZER_FLAGS_EN
    check("flag_overflow", flag_overflow, of);
    check("flag_underflow", flag_underflow, uf);
    check("flag_inexact", flag_inexact, inx);
`endif
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_exp", exp_out, xe);
      check("hold_frac", mantis_out, xf);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [25:0] m;
    logic [7:0]  e;
    int          p;
    rst_n = 1'b0; in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; mantis_in = '0;
    loss = 1'b0; operator_in = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {sign_out, exp_out, mantis_out}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(1'b0, 8'd100, 26'h1000003, 1'b0, 1'b0, 5);
    run_op(1'b0, 8'd127, 26'h0000004, 1'b0, 1'b0, 0);
    run_op(1'b1, 8'd50,  26'h0000000, 1'b0, 1'b1, 0);
    run_op(1'b0, 8'd254, 26'h3FFFFFF, 1'b0, 1'b0, 1);
    run_op(1'b0, 8'd2,   26'h0000010, 1'b1, 1'b0, 0);
    run_op(1'b1, 8'hFF,  26'h0ABCDEF, 1'b0, 1'b0, 2);
    run_op(1'b0, 8'd30,  26'h0000001, 1'b0, 1'b1, 0);

    // Abort a long normalization with an asynchronous reset.
    sign_in = 1'b1; exp_in = 8'd127; mantis_in = 26'h0000004; loss = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", {sign_out, exp_out, mantis_out}, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_in_ready", in_ready, 1);
    check("postrst_out_valid", out_valid, 0);
    run_op(1'b0, 8'd100, 26'h1000003, 1'b0, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      p = $urandom_range(0, 25);
      m = 26'($urandom) & ((26'd2 << p) - 26'd1);
      m = m | (26'd1 << p);
      if ($urandom_range(0, 15) == 0) m = '0;
      e = 8'($urandom_range(0, 254));
      if ($urandom_range(0, 15) == 0) e = 8'hFF;
      run_op(1'($urandom), e, m, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
